stat_nclus_readout: RTL
=======================

// Module: stat_nclus_readout
// PURPOSE
//  Readout sequencer for the per-spill cluster-multiplicity histogram (10 bins, 16-bit each).
//  Snapshots all bin counters at the end of live (in_live falling) or on a manual dump request.
//  Streams the snapshot as a framed 13-word packet over a valid/ready interface to DAQ readout.
//  Tracks a spill sequence number and counts triggers dropped while a frame is in flight.
// PARAMETERS
//  NBIN     10        number of histogram bins (bins 0..8 = exact nclus, bin 9 = overflow)
//  CNT_W    16        width of each bin counter and of every output word
//  HDR_TAG  16'hC105  constant value of frame word 0
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            synchronous reset, active-low
//  in_live      in   1            spill live gate, same signal that clears the histogram
//  clus_cnt     in   NBIN*CNT_W   bin counters, packed; bin k at [k*CNT_W +: CNT_W]
//  dump_req     in   1            single-cycle manual dump request
//  out_data     out  CNT_W        frame word
//  out_valid    out  1            out_data valid
//  out_ready    in   1            downstream accepts the word when out_valid & out_ready
//  out_last     out  1            high with the final (checksum) word
//  busy         out  1            high while state != IDLE
//  spill_id     out  16           number of completed frames, wraps 0xFFFF -> 0x0000
//  overrun_cnt  out  8            dropped triggers, saturates at 255
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; pre_live, out_valid, out_last, busy, out_data,
//   spill_id, overrun_cnt, word index and checksum all 0. Reset mid-frame aborts the frame
//   with no out_last and no spill_id increment.
//  trig = (pre_live & ~in_live) | dump_req. pre_live <= in_live on every cycle.
//  States: IDLE -> SEND -> IDLE.
//   IDLE: if trig, capture clus_cnt into snapshot regs at the same edge, set idx=0, csum=0,
//         go to SEND. Live-fall and dump_req in the same cycle produce exactly one frame.
//   SEND: out_valid=1 and out_data=word[idx]. On out_valid & out_ready: csum += word[idx]
//         (mod 2^CNT_W), then idx++. On acceptance of idx=NBIN+2: go to IDLE,
//         spill_id++, out_valid=0.
//  Frame words: idx0=HDR_TAG; idx1=spill_id; idx2..idx(NBIN+1)=snapshot bin 0..NBIN-1;
//   idx(NBIN+2)=csum, the 16-bit modulo sum of words 0..NBIN+1. out_last=1 only on this word.
//  Latency: trig sampled at edge N -> out_valid=1 with the header word after edge N.
//  Handshake: while out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid
//   is never deasserted before acceptance. Back-to-back words go out at 1 word/cycle when
//   out_ready is held high.
//  Snapshot isolation: clus_cnt changes after capture never affect the frame in flight.
//  Overrun: a trig in SEND is dropped; overrun_cnt++ (sticky at 255); the frame continues.
//   A trig coinciding with the final acceptance edge is also dropped (counted).
//  spill_id in the header is the pre-increment value.
//  All arithmetic is unsigned; all sums wrap modulo 2^16.
// TESTING
//  1 bins=1..10, in_live 1->0, out_ready=1 -> 13 consecutive words C105,0000,0001..000A,
//    C13C; out_last on word 13 only; spill_id=1 afterwards; busy low next cycle.
//  2 as test 1, out_ready toggling 1/0 and clus_cnt changed after capture -> identical words,
//    out_data stable in every stalled cycle.
//  3 dump_req with all bins=FFFF, spill_id=0 -> bin words FFFF, checksum C0FB.
//  4 second in_live fall and dump_req during a frame -> frame intact, overrun_cnt=2;
//    300 dropped triggers -> overrun_cnt=255.
//  5 rst_n=0 while word 5 is pending -> next cycle out_valid=0, busy=0, spill_id=0;
//    the next trig starts again at C105.
//  6 dump_req and in_live fall in the same cycle from IDLE -> exactly one frame,
//    overrun_cnt unchanged.

Source files
------------

// File: rtl/stat_nclus_readout.sv
// rtl/stat_nclus_readout.sv - snapshot and framed readout of the cluster-multiplicity histogram
module stat_nclus_readout #(
    parameter int               NBIN    = 10,
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] HDR_TAG = 16'hC105
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_live,
    input  logic [NBIN*CNT_W-1:0] clus_cnt,
    input  logic                  dump_req,
    output logic [CNT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           spill_id,
    output logic [7:0]            overrun_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam int               IDX_W    = $clog2(NBIN + 3);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBIN + 2);

    logic [0:0]            state;
    logic                  pre_live;
    logic [NBIN*CNT_W-1:0] snap;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      csum;
    logic [CNT_W-1:0]      word;
    logic                  trig;
    logic                  accept;

    assign trig   = (pre_live & ~in_live) | dump_req;
    assign accept = (state == S_SEND) & out_ready;

    // Current frame word selected by idx: header, spill id, bins, running checksum.
    always_comb begin
        word = HDR_TAG;
        if (idx == IDX_W'(1)) begin
            word = CNT_W'(spill_id);
        end
        for (int k = 0; k < NBIN; k++) begin
            if (idx == IDX_W'(k + 2)) begin
                word = snap[k*CNT_W +: CNT_W];
            end
        end
        if (idx == LAST_IDX) begin
            word = csum;
        end
    end

    // Outputs decode straight from registered state, so they hold during stalls.
    assign busy      = (state == S_SEND);
    assign out_valid = busy;
    assign out_last  = busy & (idx == LAST_IDX);
    assign out_data  = busy ? word : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pre_live    <= 1'b0;
            snap        <= '0;
            idx         <= '0;
            csum        <= '0;
            spill_id    <= '0;
            overrun_cnt <= '0;
        end else begin
            pre_live <= in_live;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        snap  <= clus_cnt;
                        idx   <= '0;
                        csum  <= '0;
                        state <= S_SEND;
                    end
                end
                default: begin
                    // A trigger while a frame is in flight, including on the final edge, is dropped.
                    if (trig && overrun_cnt != 8'hFF) begin
                        overrun_cnt <= overrun_cnt + 8'd1;
                    end
                    if (accept) begin
                        csum <= csum + word;
                        if (idx == LAST_IDX) begin
                            state    <= S_IDLE;
                            spill_id <= spill_id + 16'd1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
